i2c_byte_master: RTL

- Synthesizable I2C bus initiator.
- Executes byte-level commands (START, STOP, WRITE, READ) from the Wishbone-side controller and drives the open-drain SCL/SDA lines.
- It is the initiator end of the bus whose responder side is modelled by the i2c_if slave BFM. Benches connect this block's bus to that BFM.

---
 rtl/i2c_byte_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C initiator executing START/STOP/WRITE/READ on open-drain SCL/SDA.
// Define I2C_CLK_STRETCH_EN to hold the quarter counter while a responder stretches SCL in Q1.
module i2c_byte_master #(
   parameter int QUARTER_DIV    = 25,
   parameter int I2C_DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      s_rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd,
   input  logic [I2C_DATA_WIDTH-1:0] cmd_wdata,
   input  logic                      cmd_rd_nack,
   output logic                      rsp_valid,
   output logic [I2C_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_ack,
   output logic                      rsp_err,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      scl_oe,
   output logic                      sda_oe
);
   localparam int W  = I2C_DATA_WIDTH;
   localparam int CW = $clog2(QUARTER_DIV);
   localparam int BW = $clog2(W + 1);
   typedef enum logic [2:0] {IDLE, OWNED, START, STOP, WRITE, READ} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] q, q_n, scl_sy, sda_sy;
   logic [BW-1:0] bitn, bitn_n;
   logic [W-1:0] sh, sh_n, rdata_n;
   logic nack, nack_n, scl_oe_n, sda_oe_n, valid_n, ack_n, err_n;
   logic scl_s, sda_s, busy, hold, tick, last_bit;
   assign scl_s = scl_sy[1];
   assign sda_s = sda_sy[1];
   assign cmd_ready = state == IDLE || state == OWNED;
   assign busy = !cmd_ready;
`ifdef I2C_CLK_STRETCH_EN
   assign hold = busy && q == 2'd1 && !scl_s;
`else
   logic unused_scl;
   assign unused_scl = scl_s;
   assign hold = 1'b0;
`endif
   assign tick = busy && !hold && cnt == CW'(QUARTER_DIV - 1);
   assign last_bit = bitn == BW'(W);
   always_comb begin
      state_n = state;
      cnt_n = (!busy || tick) ? '0 : hold ? cnt : cnt + 1'b1;
      q_n = q + {1'b0, tick};
      bitn_n = bitn;
      sh_n = sh;
      nack_n = nack;
      scl_oe_n = scl_oe;
      sda_oe_n = sda_oe;
      valid_n = 1'b0;
      ack_n = rsp_ack;
      err_n = rsp_err;
      rdata_n = rsp_rdata;
      if (cmd_valid && cmd_ready) begin
         if (state == IDLE && cmd != 2'b00) begin
            valid_n = 1'b1;
            err_n = 1'b1;
            ack_n = 1'b0;
         end else begin
            state_n = cmd == 2'b00 ? START : cmd == 2'b01 ? STOP : cmd == 2'b10 ? WRITE : READ;
            bitn_n = '0;
            sh_n = cmd_wdata;
            nack_n = cmd_rd_nack;
            sda_oe_n = cmd == 2'b01 || (cmd == 2'b10 && !cmd_wdata[W-1]);
         end
      end else if (tick) begin
         if (q == 2'd0)
            scl_oe_n = 1'b0;
         if (q == 2'd1)
            sda_oe_n = state == START ? 1'b1 : state == STOP ? 1'b0 : sda_oe;
         if (q == 2'd2) begin
            scl_oe_n = state != STOP;
            if (state == READ && !last_bit)
               sh_n = {sh[W-2:0], sda_s};
            // a WRITE no longer needs the NACK latch, so it holds the sampled ACK bit
            if (state == WRITE && last_bit)
               nack_n = sda_s;
         end
         if (q == 2'd3) begin
            if (state == START || state == STOP || last_bit) begin
               state_n = state == STOP ? IDLE : OWNED;
               valid_n = 1'b1;
               err_n = 1'b0;
               ack_n = state == WRITE && !nack;
               rdata_n = state == READ ? sh : rsp_rdata;
            end else begin
               bitn_n = bitn + 1'b1;
               sh_n = state == WRITE ? sh << 1 : sh;
               sda_oe_n = bitn == BW'(W - 1) ? (state == READ && !nack) : (state == WRITE && !sh[W-2]);
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (s_rst) begin
         state <= IDLE;
         cnt <= '0;
         q <= '0;
         bitn <= '0;
         sh <= '0;
         nack <= 1'b0;
         scl_oe <= 1'b0;
         sda_oe <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_ack <= 1'b0;
         rsp_err <= 1'b0;
         rsp_rdata <= '0;
         scl_sy <= 2'b11;
         sda_sy <= 2'b11;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         q <= q_n;
         bitn <= bitn_n;
         sh <= sh_n;
         nack <= nack_n;
         scl_oe <= scl_oe_n;
         sda_oe <= sda_oe_n;
         rsp_valid <= valid_n;
         rsp_ack <= ack_n;
         rsp_err <= err_n;
         rsp_rdata <= rdata_n;
         scl_sy <= {scl_sy[0], scl_i};
         sda_sy <= {sda_sy[0], sda_i};
      end
   end
endmodule
